// File: rtl/dma_controller.sv
// ============================================================================
// dma_controller : CPU-programmed DMA sequencer (SRC/DST/LEN, GO, status, IRQ)
// Revision 1.0
// ============================================================================
`default_nettype none

module dma_controller #(
   parameter int WORD_BYTES = 4
) (
   input  logic        iClk,
   input  logic        iReset_n,
   input  logic        iCS_chipselect,
   input  logic        iCS_read,
   input  logic        iCS_write,
   input  logic [2:0]  iCS_address,
   input  logic [31:0] iCS_writedata,
   output logic [31:0] oCS_readdata,
   input  logic        iWM_wordwritten,
   output logic        oStart,
   output logic [31:0] oRM_startaddress,
   output logic [31:0] oWM_startaddress,
   output logic [31:0] oLength,
   output logic        oIRQ
);

   localparam logic [31:0] LEN_MASK = ~(32'(WORD_BYTES) - 32'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t      state, next_state;
   logic [31:0] src, dst, len;
   logic        ie, done;
   logic [29:0] remain;
   logic        cs_wr, cs_rd, busy, go, start, complete;
   logic [31:0] rd_mux;

   assign cs_wr = iCS_chipselect & iCS_write;
   assign cs_rd = iCS_chipselect & iCS_read;
   assign busy  = (state != IDLE);
   assign go    = cs_wr && (iCS_address == 3'd3) && iCS_writedata[0] && !busy;

   always_ff @(posedge iClk) begin
      if (!iReset_n) state <= IDLE;
      else           state <= next_state;
   end

   // A transfer retiring its last word in START bypasses RUN entirely.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (go && (len != 32'd0)) next_state = START;
         end
         START: begin
            start = 1'b1;
            if (iWM_wordwritten && (remain == 30'd1)) begin
               complete   = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (iWM_wordwritten && (remain == 30'd1)) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 32'd0;
      case (iCS_address)
         3'd0:    rd_mux = src;
         3'd1:    rd_mux = dst;
         3'd2:    rd_mux = len;
         3'd3:    rd_mux = {30'd0, ie, 1'b0};
         3'd4:    rd_mux = {30'd0, done, busy};
         3'd5:    rd_mux = {2'd0, remain};
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         src              <= 32'd0;
         dst              <= 32'd0;
         len              <= 32'd0;
         ie               <= 1'b0;
         done             <= 1'b0;
         remain           <= 30'd0;
         oRM_startaddress <= 32'd0;
         oWM_startaddress <= 32'd0;
         oLength          <= 32'd0;
         oCS_readdata     <= 32'd0;
      end else begin
         if (cs_wr && !busy) begin
            case (iCS_address)
               3'd0:    src <= iCS_writedata;
               3'd1:    dst <= iCS_writedata;
               3'd2:    len <= iCS_writedata & LEN_MASK;
               default: ;
            endcase
         end
         if (cs_wr && (iCS_address == 3'd3)) ie <= iCS_writedata[1];

         if (go) begin
            if (len == 32'd0) begin
               done <= 1'b1;
            end else begin
               done             <= 1'b0;
               oRM_startaddress <= src;
               oWM_startaddress <= dst;
               oLength          <= len;
               remain           <= len[31:2];
            end
         end else if (cs_wr && (iCS_address == 3'd4) && iCS_writedata[1]) begin
            done <= 1'b0;
         end

         if (busy && iWM_wordwritten && (remain != 30'd0)) remain <= remain - 30'd1;
         // Completion overrides a same-cycle DONE clear.
         if (complete) done <= 1'b1;

         if (cs_rd) oCS_readdata <= rd_mux;
      end
   end

   assign oStart = start;
   assign oIRQ   = done & ie;

endmodule

`default_nettype wire

// File: doc/dma_controller.md
# dma_controller

Register-mapped sequencer for the DMA engine. Holds the CPU-programmed source address, destination address and byte length, then issues a single start pulse to both the read master and the write master. It counts words retired by the write master, reports busy/done status, and raises a level interrupt on completion. Sits between the system CPU slave port and the read master / FIFO / write master datapath.

## Interface
- WORD_BYTES, 4, bytes per transferred word; length-to-word conversion shifts by log2(WORD_BYTES) (only 4 supported).
- iClk  in  1  system clock; all logic on rising edge.
- iReset_n  in  1  reset, synchronous, active-low.
- iCS_chipselect  in  1  slave select.
- iCS_read  in  1  register read strobe (qualified by chipselect).
- iCS_write  in  1  register write strobe (qualified by chipselect).
- iCS_address  in  3  word index of register.
- iCS_writedata  in  32  write data.
- oCS_readdata  out  32  registered read data, 1-cycle latency.
- iWM_wordwritten  in  1  one-cycle pulse per word accepted by the write master's slave.
- oStart  out  1  one-cycle start pulse to read and write masters.
- oRM_startaddress  out  32  source address presented to read master.
- oWM_startaddress  out  32  destination address presented to write master.
- oLength  out  32  byte length presented to both masters.
- oIRQ  out  1  level interrupt = DONE & IE.

## Operation
- Register map (word index):
  - 0 SRC (RW).
  - 1 DST (RW).
  - 2 LEN (RW, bits[1:0] read back 0).
  - 3 CTRL: bit0 GO (write-1 trigger, reads 0); bit1 IE (RW).
  - 4 STATUS: bit0 BUSY (RO); bit1 DONE (write 1 clears).
  - 5 REMAIN (RO, words outstanding).
  - 6–7: read 0, writes ignored.
- Writes to SRC/DST/LEN while BUSY are ignored. GO while BUSY is ignored. IE is writable any time.
- State machine:
  - IDLE: on a GO write:
    - If LEN==0: set DONE, clear nothing else, stay in IDLE. No oStart.
    - If LEN!=0: clear DONE, latch SRC/DST/LEN into oRM_startaddress/oWM_startaddress/oLength, load REMAIN=LEN>>2, set BUSY, and go to START.
  - START: oStart=1 for exactly this cycle → RUN.
  - RUN: each iWM_wordwritten decrements REMAIN.
    - When REMAIN==1 and iWM_wordwritten=1: REMAIN←0, BUSY←0, DONE←1, → IDLE.
    - iWM_wordwritten while REMAIN==0 is ignored; REMAIN never wraps.
- Arithmetic is 32-bit unsigned. REMAIN width is 30 bits, zero-extended on read.
- Simultaneous events:
  - Completion and a DONE-clear write in the same cycle: set wins, DONE=1.
  - iWM_wordwritten in the START cycle: counts. A transfer that retires in START (LEN=4) completes from START directly to IDLE, with oStart still pulsing in that cycle.
- Reset values (all registers/outputs): SRC=DST=LEN=0, IE=0, BUSY=0, DONE=0, REMAIN=0, oStart=0, oRM_startaddress=oWM_startaddress=oLength=0, oCS_readdata=0, oIRQ=0, state IDLE.
- Reset mid-transfer returns every register and output to its reset value on the next edge. Masters are restarted only by a new GO.

## Timing
- Register write takes effect on the edge where chipselect&write is sampled.
- GO accepted at edge N → state START after edge N → oStart high in cycle N+1 only. Address/length outputs are stable from cycle N+1 until the next GO.
- Read: chipselect&read at edge N → oCS_readdata valid after edge N. It holds its value when no read is strobed.
- oIRQ is combinational from the DONE and IE flops; it rises the cycle after the last iWM_wordwritten.
- Minimum GO-to-IDLE for LEN=4 with iWM_wordwritten in cycle N+1: BUSY high for exactly 1 cycle.

## Test plan
- Reset: hold iReset_n=0 for 2 cycles with random bus activity → all outputs 0. Reads of 0–5 return 0.
- Basic transfer: SRC=0x1000, DST=0x2000, LEN=0x10, IE=1, GO → single oStart pulse next cycle with outputs 0x1000/0x2000/0x10. Then 4 iWM_wordwritten pulses → REMAIN 4→0, DONE=1, oIRQ=1. Write STATUS=0x2 → oIRQ=0.
- LEN=0 GO → no oStart, DONE=1 immediately, BUSY never set.
- Busy protection: during RUN write SRC=0xFFFF, LEN=0x40, GO → outputs and REMAIN unchanged, no second oStart.
- Completion collides with STATUS DONE-clear write in the same cycle → DONE=1 afterward.
- Reset asserted with REMAIN=3 → next cycle BUSY=0, REMAIN=0. A following GO with LEN=8 restarts normally with REMAIN=2.
